// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX feeder and its byte FIFO.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWaitBusy,
      StWaitDone,
      StGap
   } state_e;

   // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart8_tx_feeder_if.sv
// Producer, UART TX and status signals of the feeder, grouped for port use.
interface uart8_tx_feeder_if
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) ();

   localparam int unsigned LVL_W = level_w(DEPTH);

   logic              wr_valid;
   logic [BYTE_W-1:0] wr_data;
   logic              wr_ready;
   logic              drain_en;
   logic              clr_flags;
   logic              tx_en;
   logic              tx_start;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_busy;
   logic              tx_done;
   logic [LVL_W-1:0]  level;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              start_err;

   modport master (
      output wr_valid, wr_data, drain_en, clr_flags, tx_busy, tx_done,
      input  wr_ready, tx_en, tx_start, tx_data, level, empty, full, overflow, start_err
   );

   modport slave (
      input  wr_valid, wr_data, drain_en, clr_flags, tx_busy, tx_done,
      output wr_ready, tx_en, tx_start, tx_data, level, empty, full, overflow, start_err
   );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with wrapping pointers and an explicit occupancy counter.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [BYTE_W-1:0]         i_data,
   output logic [BYTE_W-1:0]         o_data,
   output logic [level_w(DEPTH)-1:0] o_level,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = level_w(DEPTH);

   logic [BYTE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              w_push;
   logic              w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);

endmodule

// File: rtl/uart8_tx_feeder.sv
// Streams buffered bytes into a one-shot UART TX: one start per byte, waiting
// for each frame to finish before the next, with sticky overflow/start-error flags.
module uart8_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned START_TIMEOUT = 8
) (
   input logic               clk,
   input logic               rst_n,
   uart8_tx_feeder_if.slave  io_bus
);

   localparam int unsigned LVL_W = level_w(DEPTH);
   localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

   state_e            r_state;
   state_e            w_state_d;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_d;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [BYTE_W-1:0] r_tx_data;
   logic              r_tx_en;
   logic              r_overflow;
   logic              r_start_err;
   logic              w_push;
   logic              w_pop;
   logic              w_load;
   logic              w_timeout;
   logic              w_full;
   logic              w_empty;
   logic [BYTE_W-1:0] w_head;
   logic [LVL_W-1:0]  w_level;

   assign w_push = io_bus.wr_valid && !w_full;

   uart_byte_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_data (io_bus.wr_data),
      .o_data (w_head),
      .o_level(w_level),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_pop     = 1'b0;
      w_load    = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.drain_en && !w_empty && !io_bus.tx_busy) begin
               w_state_d = StLoad;
               w_load    = 1'b1;
            end
         end
         StLoad: begin
            w_pop     = 1'b1;
            w_cnt_d   = '0;
            w_state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (io_bus.tx_busy) begin
               w_state_d = StWaitDone;
            end else begin
               w_cnt_d = w_cnt_inc;
               // The byte is dropped on timeout; the UART never took it.
               if (w_cnt_inc == CNT_W'(START_TIMEOUT)) begin
                  w_timeout = 1'b1;
                  w_state_d = StIdle;
               end
            end
         end
         StWaitDone: begin
            if (io_bus.tx_done || !io_bus.tx_busy) w_state_d = StGap;
         end
         StGap:   w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // tx_data is captured on entry to LOAD so it is valid during the start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_tx_data   <= '0;
         r_tx_en     <= 1'b0;
         r_overflow  <= 1'b0;
         r_start_err <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_tx_en     <= io_bus.drain_en;
         if (w_load) r_tx_data <= w_head;
         r_overflow  <= (io_bus.wr_valid && w_full) || (r_overflow && !io_bus.clr_flags);
         r_start_err <= w_timeout || (r_start_err && !io_bus.clr_flags);
      end
   end

   assign io_bus.wr_ready  = !w_full;
   assign io_bus.tx_en     = r_tx_en;
   assign io_bus.tx_start  = (r_state == StLoad);
   assign io_bus.tx_data   = r_tx_data;
   assign io_bus.level     = w_level;
   assign io_bus.empty     = w_empty;
   assign io_bus.full      = w_full;
   assign io_bus.overflow  = r_overflow;
   assign io_bus.start_err = r_start_err;

endmodule

// File: tb/tb_uart8_tx_feeder.sv
// Scoreboard bench: accepted bytes queue up as expected UART bytes; a negedge
// monitor doubling as the UART model pops and compares on every tx_start.
module tb_uart8_tx_feeder;
   import uart_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart8_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

   uart8_tx_feeder #(
      .DEPTH        (DEPTH),
      .START_TIMEOUT(TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_bus(bus)
   );

   int         n_cmp      = 0;
   int         n_err      = 0;
   int         n_starts   = 0;
   int         u_cnt      = 0;
   int         frame_len  = 10;
   bit         never_busy = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] last_byte  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail(input string name, input string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   // UART model + scoreboard monitor, both on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.tx_busy = 1'b0;
         bus.tx_done = 1'b0;
         u_cnt       = 0;
      end else begin
         bus.tx_done = 1'b0;
         if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
               bus.tx_busy = 1'b0;
               bus.tx_done = 1'b1;
               check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, last_byte});
            end
         end
         if (bus.tx_start) begin
            n_starts++;
            if (exp_q.size() == 0)
               fail("unexpected_start", $sformatf("got start with 0x%0h, required no start",
                                                  bus.tx_data));
            else
               check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
            last_byte = bus.tx_data;
            if (!never_busy) begin
               bus.tx_busy = 1'b1;
               u_cnt       = frame_len;
            end
         end
      end
   end

   task automatic drive_drain(input logic v);
      @(posedge clk);
      #1 bus.drain_en = v;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 bus.clr_flags = 1'b1;
      @(posedge clk);
      #1 bus.clr_flags = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = b;
      @(negedge clk);
      #1 check("wr_ready_on_write", {31'd0, bus.wr_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back(b);
      #1 bus.wr_valid = 1'b0;
   endtask

   task automatic wait_start(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         #1;
         if (bus.tx_start) seen = 1'b1;
      end
      if (!seen) fail("wait_start", "got no tx_start, required one within budget");
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !bus.tx_busy && !bus.tx_done) ok = 1'b1;
      end
      if (!ok) fail("wait_idle", $sformatf("got %0d bytes still pending, required 0", exp_q.size()));
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int acc;
      logic [7:0] b;

      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.drain_en  = 1'b0;
      bus.clr_flags = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check("rst_level", {27'd0, bus.level}, 32'd0);
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_full", {31'd0, bus.full}, 32'd0);
      check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      check("rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
      check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      check("rst_start_err", {31'd0, bus.start_err}, 32'd0);
      rst_n = 1'b1;

      // Single byte, long frame, start latency
      frame_len = 100;
      drive_drain(1'b1);
      base = n_starts;
      write_byte(8'hA5);
      @(negedge clk);
      #1 check("latency_cycle1", {31'd0, bus.tx_start}, 32'd0);
      @(negedge clk);
      #1 check("latency_cycle2", {31'd0, bus.tx_start}, 32'd1);
      wait_idle(200);
      check("single_starts", n_starts - base, 32'd1);
      check("single_level", {27'd0, bus.level}, 32'd0);
      check("single_empty", {31'd0, bus.empty}, 32'd1);
      check("single_tx_en", {31'd0, bus.tx_en}, 32'd1);

      // Burst into a gated FIFO; overflow set wins over a same-cycle clear
      drive_drain(1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         bus.wr_valid  = 1'b1;
         bus.wr_data   = 8'(i);
         bus.clr_flags = (i == 19);
         @(negedge clk);
         #1 check($sformatf("burst_wr_ready_%0d", i), {31'd0, bus.wr_ready}, {31'd0, i < 16});
         @(posedge clk);
         if (i < 16) exp_q.push_back(8'(i));
         #1;
      end
      bus.wr_valid  = 1'b0;
      bus.clr_flags = 1'b0;
      @(negedge clk);
      #1;
      check("burst_level", {27'd0, bus.level}, 32'd16);
      check("burst_full", {31'd0, bus.full}, 32'd1);
      check("burst_overflow_set_wins", {31'd0, bus.overflow}, 32'd1);
      pulse_clr();
      @(negedge clk);
      #1 check("burst_overflow_clr", {31'd0, bus.overflow}, 32'd0);
      frame_len = 6;
      base = n_starts;
      drive_drain(1'b1);
      wait_idle(500);
      check("burst_starts", n_starts - base, 32'd16);
      check("burst_level_end", {27'd0, bus.level}, 32'd0);

      // Write on the LOAD cycle: push and pop together keep level at 3
      frame_len = 10;
      drive_drain(1'b0);
      for (int i = 0; i < 3; i++) write_byte(8'($urandom));
      drive_drain(1'b1);
      wait_start(20);
      b = 8'($urandom);
      bus.wr_valid = 1'b1;
      bus.wr_data  = b;
      @(posedge clk);
      exp_q.push_back(b);
      #1 bus.wr_valid = 1'b0;
      @(negedge clk);
      #1 check("pushpop_level", {27'd0, bus.level}, 32'd3);
      wait_idle(200);

      // Start timeout: UART never goes busy
      never_busy = 1'b1;
      base = n_starts;
      write_byte(8'h3C);
      wait_start(10);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         #1;
         if (k == TMO)     check("tmo_not_yet", {31'd0, bus.start_err}, 32'd0);
         if (k == TMO + 1) check("tmo_start_err", {31'd0, bus.start_err}, 32'd1);
      end
      repeat (10) @(negedge clk);
      #1;
      check("tmo_single_start", n_starts - base, 32'd1);
      check("tmo_level", {27'd0, bus.level}, 32'd0);
      pulse_clr();
      @(negedge clk);
      #1 check("tmo_clr", {31'd0, bus.start_err}, 32'd0);
      never_busy = 1'b0;

      // Drop drain_en mid-frame with two bytes still queued
      frame_len = 20;
      drive_drain(1'b0);
      for (int i = 0; i < 3; i++) write_byte(8'($urandom));
      drive_drain(1'b1);
      wait_start(20);
      base = n_starts;
      repeat (3) @(negedge clk);
      drive_drain(1'b0);
      repeat (30) @(negedge clk);
      #1;
      check("gate_no_new_start", n_starts - base, 32'd0);
      check("gate_level", {27'd0, bus.level}, 32'd2);
      check("gate_tx_en", {31'd0, bus.tx_en}, 32'd0);
      check("gate_busy_low", {31'd0, bus.tx_busy}, 32'd0);
      drive_drain(1'b1);
      wait_idle(200);
      check("gate_resume_starts", n_starts - base, 32'd2);
      check("gate_level_end", {27'd0, bus.level}, 32'd0);

      // Random streaming, writes kept below capacity so none should drop
      base = n_starts;
      acc  = 0;
      for (int k = 0; k < 24; k++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         frame_len = int'($urandom_range(2, 8));
         for (int w = 0; w < 300 && (acc - (n_starts - base)) >= int'(DEPTH) - 1; w++)
            @(posedge clk);
         write_byte(8'($urandom));
         acc++;
      end
      wait_idle(600);
      check("rand_starts", n_starts - base, 32'd24);
      check("rand_overflow", {31'd0, bus.overflow}, 32'd0);
      check("rand_level", {27'd0, bus.level}, 32'd0);

      // Asynchronous reset in the middle of a frame
      frame_len = 30;
      write_byte(8'h5A);
      wait_start(20);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tx_start", {31'd0, bus.tx_start}, 32'd0);
      check("arst_tx_data", {24'd0, bus.tx_data}, 32'd0);
      check("arst_tx_en", {31'd0, bus.tx_en}, 32'd0);
      check("arst_level", {27'd0, bus.level}, 32'd0);
      check("arst_empty", {31'd0, bus.empty}, 32'd1);
      check("arst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1 check("arst_after_release", {31'd0, bus.tx_start}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart8_tx_feeder.md
Name: uart8_tx_feeder

Overview:
- Byte FIFO plus handshake FSM placed directly upstream of the 8-bit UART transmitter.
- Accepts bytes from a valid/ready producer, buffers up to DEPTH bytes, and issues one transmit start per byte to the UART TX interface (txEn/txStart/in/txBusy/txDone).
- Waits for each frame to complete before launching the next.
- Turns the UART's one-shot start interface into a streaming interface with back-pressure.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- START_TIMEOUT, 8, cycles to wait for tx_busy to rise after a start before declaring a start error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- drain_en  in  1  allows the FIFO to feed the UART; FIFO writes are still accepted when low.
- wr_valid  in  1  producer has a byte.
- wr_data  in  8  producer byte.
- wr_ready  out  1  FIFO can accept; equals !full.
- tx_en  out  1  to UART txEn; equals drain_en, registered.
- tx_start  out  1  to UART txStart; one-cycle pulse.
- tx_data  out  8  to UART in; held stable from the start pulse until the frame completes.
- tx_busy  in  1  from UART txBusy.
- tx_done  in  1  from UART txDone.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky; set by a write attempt while full.
- clr_flags  in  1  clears overflow and start_err.
- start_err  out  1  sticky; UART never went busy after a start.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (rst_n).
- Reset values: pointers 0, level 0, empty 1, full 0, wr_ready 1, tx_en 0, tx_start 0, tx_data 0, overflow 0, start_err 0, FSM in IDLE.
- Write: a byte is accepted when wr_valid && wr_ready at a rising edge. wr_valid while full is dropped, sets overflow, and leaves the FIFO unchanged.
- Simultaneous write and pop:
  - Allowed; level is unchanged.
  - When full, the pop frees space only on the next cycle (wr_ready stays combinationally !full).
- Pointer arithmetic:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is tracked by an explicit counter.
- FSM states:
  - IDLE: if drain_en && !empty && !tx_busy, go to LOAD.
  - LOAD (1 cycle): pop the head into tx_data, assert tx_start for exactly this cycle, clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If tx_busy==1, go to WAIT_DONE.
    - Else increment the counter. At START_TIMEOUT, set start_err and go to IDLE; the byte is discarded, not re-queued.
  - WAIT_DONE:
    - The frame is complete on the first cycle with tx_done==1 or tx_busy==0.
    - Then go to GAP.
  - GAP (1 cycle): go to IDLE. This guarantees at least one idle cycle between frames.
- Latency: a byte written into an empty FIFO with the FSM in IDLE and drain_en=1 produces tx_start 2 cycles after the write edge (write, IDLE sees !empty, LOAD).
- Throughput: at most one start per UART frame plus 2 cycles.
- drain_en deasserted mid-frame:
  - The current frame runs to completion.
  - The FSM then parks in IDLE; tx_en follows drain_en one cycle later.
- clr_flags and a set event in the same cycle: the set wins.
- Reset mid-frame: all state is cleared immediately and tx_start drops. The UART is expected to be reset or disabled by the same reset.
- tx_data holds its last value while in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP);
  - localparam BYTE_W=8;
  - a function for the level width.
- One sub-module is natural: uart_byte_fifo (parameter DEPTH; push/pop/data/level/full/empty).
  - The top level adds the FSM, timeout counter, and sticky flags.
  - The same FIFO will serve the future RX-side consumer.

Test Plan:
- Single byte: reset, drain_en=1, write 0xA5 with a UART model (busy 1 for 100 cycles, then done) -> exactly one tx_start, tx_data=0xA5 held until done, level returns to 0, empty=1.
- Burst and back-pressure:
  - Stimulus: DEPTH=16, drain_en=0, write 20 bytes 0x00..0x13 with wr_valid held high.
  - Required response: wr_ready falls after 16 writes; the 4 extra bytes are dropped with overflow=1 when not gated by the bench; level=16, full=1.
  - Then drain_en=1 -> the UART receives 0x00..0x0F in order, one start per frame.
- Simultaneous push/pop: FIFO at level 3 with a write on the LOAD cycle -> level stays 3, order preserved.
- Start timeout: UART model never asserts busy, write 0x3C -> tx_start once, start_err=1 after 8 cycles, FSM returns to IDLE, level=0. clr_flags -> start_err=0.
- Drain gating mid-frame: drop drain_en while in WAIT_DONE with 2 bytes queued -> the current frame completes, no new tx_start, level=2. Re-enable -> the remaining 2 bytes are sent.
- Async reset mid-frame: assert rst_n=0 between clock edges during WAIT_DONE -> all outputs take reset values immediately, without waiting for a clock edge.
